fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 94 +++++++++
 tb/tb_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch: one outstanding memory request, 2-entry {pc, inst} queue to decode
module fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   output logic        o_IReqValid_1,
   output logic [63:0] o_IReqAddr_64,
   input  logic        i_IReqReady_1,
   input  logic        i_IRespValid_1,
   input  logic [31:0] i_IRespData_32,
   input  logic        i_Redirect_1,
   input  logic [63:0] i_RedirectPC_64,
   output logic        o_DecValid_1,
   input  logic        i_DecReady_1,
   output logic [63:0] o_PC_64,
   output logic [31:0] o_Inst_32
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [63:0] fetch_pc_q, fetch_pc_d;
   logic [63:0] cap_pc_q;
   logic [63:0] fifo_pc   [2];
   logic [31:0] fifo_inst [2];
   logic        rd_ptr_q, wr_ptr_q;
   logic [1:0]  count_q;
   logic        req_hs, push, pop;
   logic        unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^i_RedirectPC_64[1:0];

   assign o_IReqValid_1 = !i_Rst && (state_q == S_REQ) && (count_q != 2'd2) && !i_Redirect_1;
   assign o_IReqAddr_64 = fetch_pc_q;
   assign o_DecValid_1  = !i_Rst && (count_q != 2'd0) && !i_Redirect_1;
   assign o_PC_64       = fifo_pc[rd_ptr_q];
   assign o_Inst_32     = fifo_inst[rd_ptr_q];

   assign req_hs = o_IReqValid_1 && i_IReqReady_1;
   assign push   = (state_q == S_WAIT) && i_IRespValid_1 && !i_Redirect_1;
   assign pop    = o_DecValid_1 && i_DecReady_1;

   // A response in WAIT or DRAIN always returns to REQ; redirect only decides whether it is kept.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      case (state_q)
         S_REQ:   if (req_hs) state_d = S_WAIT;
         S_WAIT:  begin
            if (i_IRespValid_1)    state_d = S_REQ;
            else if (i_Redirect_1) state_d = S_DRAIN;
         end
         S_DRAIN: if (i_IRespValid_1) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
      if (i_Redirect_1)
         fetch_pc_d = {i_RedirectPC_64[63:2], 2'b00};
      else if (req_hs)
         fetch_pc_d = fetch_pc_q + 64'd4;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if (i_Redirect_1) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
         end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // Payload storage needs no reset: count gates every use of it.
   always_ff @(posedge i_Clk) begin
      if (req_hs) cap_pc_q <= fetch_pc_q;
      if (push) begin
         fifo_pc[wr_ptr_q]   <= cap_pc_q;
         fifo_inst[wr_ptr_q] <= i_IRespData_32;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for fetch
module tb_fetch;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic        i_Clk, i_Rst;
   logic        o_IReqValid_1, i_IReqReady_1;
   logic [63:0] o_IReqAddr_64;
   logic        i_IRespValid_1;
   logic [31:0] i_IRespData_32;
   logic        i_Redirect_1;
   logic [63:0] i_RedirectPC_64;
   logic        o_DecValid_1, i_DecReady_1;
   logic [63:0] o_PC_64;
   logic [31:0] o_Inst_32;

   int n_checks = 0;
   int n_errors = 0;
   bit auto_resp = 0;
   logic [63:0] got_pc [$];
   logic [31:0] got_inst [$];
   logic [63:0] req_log [$];

   fetch #(.RESET_PC(RESET_PC)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst),
      .o_IReqValid_1(o_IReqValid_1), .o_IReqAddr_64(o_IReqAddr_64), .i_IReqReady_1(i_IReqReady_1),
      .i_IRespValid_1(i_IRespValid_1), .i_IRespData_32(i_IRespData_32),
      .i_Redirect_1(i_Redirect_1), .i_RedirectPC_64(i_RedirectPC_64),
      .o_DecValid_1(o_DecValid_1), .i_DecReady_1(i_DecReady_1),
      .o_PC_64(o_PC_64), .o_Inst_32(o_Inst_32)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return a[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: log handshakes seen before the edge, then play memory (1-cycle response).
   task automatic tick();
      logic        req_hs;
      logic [63:0] addr;
      #1;
      req_hs = o_IReqValid_1 && i_IReqReady_1;
      addr   = o_IReqAddr_64;
      if (req_hs) req_log.push_back(addr);
      if (o_DecValid_1 && i_DecReady_1) begin
         got_pc.push_back(o_PC_64);
         got_inst.push_back(o_Inst_32);
      end
      @(posedge i_Clk);
      #1;
      if (auto_resp) begin
         i_IRespValid_1 = req_hs;
         i_IRespData_32 = req_hs ? inst_of(addr) : 32'h0;
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic reset_dut();
      i_Rst = 1'b1; i_Redirect_1 = 1'b0; i_IRespValid_1 = 1'b0; auto_resp = 0;
      run(2);
      got_pc.delete(); got_inst.delete(); req_log.delete();
      i_Rst = 1'b0;
      #1;
   endtask

   task automatic check_stream(input string tag, input logic [63:0] base);
      for (int i = 0; i < got_pc.size(); i++) begin
         check({tag, "_pc"}, got_pc[i], base + 64'(4 * i));
         check({tag, "_inst"}, {32'h0, got_inst[i]}, {32'h0, inst_of(base + 64'(4 * i))});
      end
   endtask

   initial begin
      i_Rst = 1'b1; i_IReqReady_1 = 1'b0; i_IRespValid_1 = 1'b0; i_IRespData_32 = 32'h0;
      i_Redirect_1 = 1'b0; i_RedirectPC_64 = 64'h0; i_DecReady_1 = 1'b0;

      // reset behaviour
      i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b1;
      run(2);
      check("rst_ireq_valid", o_IReqValid_1, 0);
      check("rst_dec_valid", o_DecValid_1, 0);
      i_Rst = 1'b0; #1;
      check("post_rst_ireq_valid", o_IReqValid_1, 1);
      check("post_rst_addr", o_IReqAddr_64, RESET_PC);

      // streaming fetch
      reset_dut();
      auto_resp = 1; i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b1;
      run(12);
      i_IReqReady_1 = 1'b0;
      run(4);
      check("stream_count_ge3", got_pc.size() >= 3, 1);
      check("stream_no_loss", got_pc.size(), req_log.size());
      check_stream("stream", RESET_PC);

      // decode stall: queue fills at two entries
      reset_dut();
      auto_resp = 1; i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b0;
      run(12);
      check("stall_req_count", req_log.size(), 2);
      check("stall_ireq_valid", o_IReqValid_1, 0);
      check("stall_dec_valid", o_DecValid_1, 1);
      check("stall_head_pc", o_PC_64, RESET_PC);
      i_DecReady_1 = 1'b1;
      tick();
      i_DecReady_1 = 1'b0; #1;
      check("pop_ireq_valid", o_IReqValid_1, 1);
      check("pop_ireq_addr", o_IReqAddr_64, RESET_PC + 64'd8);
      check("pop_head_pc", o_PC_64, RESET_PC + 64'd4);
      i_DecReady_1 = 1'b1;
      run(10);
      i_IReqReady_1 = 1'b0;
      run(4);
      check("stall_no_loss", got_pc.size(), req_log.size());
      check_stream("stall", RESET_PC);

      // redirect while waiting, response three cycles later is dropped
      reset_dut();
      auto_resp = 0; i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b1;
      tick();
      i_Redirect_1 = 1'b1; i_RedirectPC_64 = 64'h1000; #1;
      check("redir_wait_ireq_valid", o_IReqValid_1, 0);
      tick();
      i_Redirect_1 = 1'b0; #1;
      check("drain_ireq_valid", o_IReqValid_1, 0);
      run(2);
      i_IRespValid_1 = 1'b1; i_IRespData_32 = 32'hDEAD_BEEF; #1;
      check("drain_dec_valid", o_DecValid_1, 0);
      tick();
      i_IRespValid_1 = 1'b0; #1;
      check("after_drain_ireq_valid", o_IReqValid_1, 1);
      check("after_drain_addr", o_IReqAddr_64, 64'h1000);
      check("after_drain_dec_valid", o_DecValid_1, 0);
      auto_resp = 1;
      run(6);
      i_IReqReady_1 = 1'b0;
      run(3);
      check("redir_first_pc", got_pc[0], 64'h1000);
      check("redir_first_inst", {32'h0, got_inst[0]}, {32'h0, inst_of(64'h1000)});

      // redirect coincident with response and pop at count=1
      reset_dut();
      auto_resp = 1; i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b0;
      run(2);
      auto_resp = 0;
      tick();
      check("c1_dec_valid", o_DecValid_1, 1);
      check("c1_head_pc", o_PC_64, RESET_PC);
      i_IRespValid_1 = 1'b1; i_IRespData_32 = 32'hCAFE_F00D;
      i_Redirect_1 = 1'b1; i_RedirectPC_64 = 64'h2003; i_DecReady_1 = 1'b1; #1;
      check("c1_redir_dec_valid", o_DecValid_1, 0);
      check("c1_redir_ireq_valid", o_IReqValid_1, 0);
      tick();
      i_IRespValid_1 = 1'b0; i_Redirect_1 = 1'b0; i_DecReady_1 = 1'b0; #1;
      check("c1_empty", o_DecValid_1, 0);
      check("c1_resume_valid", o_IReqValid_1, 1);
      check("c1_resume_addr", o_IReqAddr_64, 64'h2000);
      check("c1_no_pop", got_pc.size(), 0);
      auto_resp = 1; i_DecReady_1 = 1'b1;
      run(6);
      i_IReqReady_1 = 1'b0;
      run(3);
      check("c1_first_pc", got_pc[0], 64'h2000);

      // fetch_pc wraps past the top of the address space
      reset_dut();
      auto_resp = 1; i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b0;
      i_Redirect_1 = 1'b1; i_RedirectPC_64 = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      i_Redirect_1 = 1'b0; #1;
      check("wrap_addr_top", o_IReqAddr_64, 64'hFFFF_FFFF_FFFF_FFFC);
      run(2);
      check("wrap_addr_zero", o_IReqAddr_64, 64'h0);
      check("wrap_head_pc", o_PC_64, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_head_inst", {32'h0, o_Inst_32}, {32'h0, inst_of(64'hFFFF_FFFF_FFFF_FFFC)});

      // reset in the middle of DRAIN
      reset_dut();
      auto_resp = 0; i_IReqReady_1 = 1'b1; i_DecReady_1 = 1'b1;
      tick();
      i_Redirect_1 = 1'b1; i_RedirectPC_64 = 64'h3000;
      tick();
      i_Redirect_1 = 1'b0; i_Rst = 1'b1; #1;
      check("drain_rst_ireq_valid", o_IReqValid_1, 0);
      check("drain_rst_dec_valid", o_DecValid_1, 0);
      tick();
      i_Rst = 1'b0; #1;
      check("drain_rst_req_valid", o_IReqValid_1, 1);
      check("drain_rst_addr", o_IReqAddr_64, RESET_PC);
      check("drain_rst_dec_empty", o_DecValid_1, 0);
      auto_resp = 1;
      run(6);
      i_IReqReady_1 = 1'b0;
      run(3);
      check("drain_rst_first_pc", got_pc[0], RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
